// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  alu_pkg : ALU op encodings and well-known register numbers
//  Revision: 1.0
// ============================================================================
package alu_pkg;
   localparam logic [3:0] ALUC_ADD = 4'b0000;
   localparam logic [3:0] ALUC_SUB = 4'b0100;
   localparam logic [3:0] ALUC_AND = 4'b0001;
   localparam logic [3:0] ALUC_OR  = 4'b0101;
   localparam logic [3:0] ALUC_XOR = 4'b0010;
   localparam logic [3:0] ALUC_LUI = 4'b0110;
   localparam logic [3:0] ALUC_SLL = 4'b0011;
   localparam logic [3:0] ALUC_SRL = 4'b0111;
   localparam logic [3:0] ALUC_SRA = 4'b1111;
   localparam logic [3:0] ALUC_LE  = 4'b1011;

   localparam logic [4:0] REG_RA   = 5'd31;
   localparam logic [4:0] REG_ZERO = 5'd0;
endpackage
`default_nettype wire

// File: rtl/id_ex_stage_if.sv
`default_nettype none
// ============================================================================
//  id_ex_stage_if : decoded ID-stage fields into EX, load-use request back
//  Revision: 1.0
// ============================================================================
interface id_ex_stage_if #(
   parameter int XLEN = 32,
   parameter int RNW  = 5
);
   logic [XLEN-1:0] da;
   logic [XLEN-1:0] db;
   logic [XLEN-1:0] dimm;
   logic [4:0]      dsa;
   logic [XLEN-1:0] dpc4;
   logic [RNW-1:0]  drs;
   logic [RNW-1:0]  drt;
   logic [RNW-1:0]  drn;
   logic [3:0]      daluc;
   logic            dwreg;
   logic            dm2reg;
   logic            dwmem;
   logic            dshift;
   logic            daluimm;
   logic            djal;
   logic            dusers;
   logic            duset;
   logic            load_use;

   modport master (
      output da, db, dimm, dsa, dpc4, drs, drt, drn, daluc,
             dwreg, dm2reg, dwmem, dshift, daluimm, djal, dusers, duset,
      input  load_use
   );

   modport slave (
      input  da, db, dimm, dsa, dpc4, drs, drt, drn, daluc,
             dwreg, dm2reg, dwmem, dshift, daluimm, djal, dusers, duset,
      output load_use
   );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage_fwd_mux.sv
`default_nettype none
// ============================================================================
//  fwd_mux : EX-stage operand forwarding from MEM (younger) then WB
//  Revision: 1.0
// ============================================================================
module fwd_mux
   import alu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int RNW  = 5
) (
   input  wire logic [RNW-1:0]  rn,
   input  wire logic [XLEN-1:0] val,
   input  wire logic            mwreg,
   input  wire logic            mm2reg,
   input  wire logic [RNW-1:0]  mrn,
   input  wire logic [XLEN-1:0] malu,
   input  wire logic            wwreg,
   input  wire logic [RNW-1:0]  wrn,
   input  wire logic [XLEN-1:0] wdata,
   output logic      [XLEN-1:0] fwd
);
   logic w_nonzero;
   logic w_mem_hit;
   logic w_wb_hit;

   // A load in MEM has no data yet; that case is covered by the load-use stall.
   assign w_nonzero = (rn != RNW'(REG_ZERO));
   assign w_mem_hit = w_nonzero & mwreg & ~mm2reg & (mrn == rn);
   assign w_wb_hit  = w_nonzero & wwreg & (wrn == rn);

   always_comb begin
      fwd = val;
      if (w_mem_hit)
         fwd = malu;
      else if (w_wb_hit)
         fwd = wdata;
   end
endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  id_ex_stage : ID/EX pipeline register with forwarding and ALU operand select
//  Revision: 1.0
// ============================================================================
module id_ex_stage
   import alu_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int RNW  = 5
) (
   input  wire logic            clk,
   input  wire logic            clrn,
   input  wire logic            hold,
   input  wire logic            flush,
   id_ex_stage_if.slave         id,
   input  wire logic            mwreg,
   input  wire logic            mm2reg,
   input  wire logic [RNW-1:0]  mrn,
   input  wire logic [XLEN-1:0] malu,
   input  wire logic            wwreg,
   input  wire logic [RNW-1:0]  wrn,
   input  wire logic [XLEN-1:0] wdata,
   output logic      [XLEN-1:0] ea,
   output logic      [XLEN-1:0] eb,
   output logic      [3:0]      ealuc,
   output logic      [XLEN-1:0] estore,
   output logic      [RNW-1:0]  ern,
   output logic                 ewreg,
   output logic                 em2reg,
   output logic                 ewmem
);
   logic [XLEN-1:0] r_a;
   logic [XLEN-1:0] r_b;
   logic [XLEN-1:0] r_imm;
   logic [4:0]      r_sa;
   logic [XLEN-1:0] r_pc4;
   logic [RNW-1:0]  r_rs;
   logic [RNW-1:0]  r_rt;
   logic [RNW-1:0]  r_rn;
   logic [3:0]      r_aluc;
   logic            r_wreg;
   logic            r_m2reg;
   logic            r_wmem;
   logic            r_shift;
   logic            r_aluimm;
   logic            r_jal;

   logic [XLEN-1:0] w_fwd_rs;
   logic [XLEN-1:0] w_fwd_rt;

   // The all-zero state is the bubble: rn=0 and every control flag clear.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn || flush) begin
         r_a      <= '0;
         r_b      <= '0;
         r_imm    <= '0;
         r_sa     <= '0;
         r_pc4    <= '0;
         r_rs     <= '0;
         r_rt     <= '0;
         r_rn     <= '0;
         r_aluc   <= ALUC_ADD;
         r_wreg   <= 1'b0;
         r_m2reg  <= 1'b0;
         r_wmem   <= 1'b0;
         r_shift  <= 1'b0;
         r_aluimm <= 1'b0;
         r_jal    <= 1'b0;
      end else if (!hold) begin
         r_a      <= id.da;
         r_b      <= id.db;
         r_imm    <= id.dimm;
         r_sa     <= id.dsa;
         r_pc4    <= id.dpc4;
         r_rs     <= id.drs;
         r_rt     <= id.drt;
         r_rn     <= id.djal ? RNW'(REG_RA) : id.drn;
         r_aluc   <= id.djal ? ALUC_ADD : id.daluc;
         r_wreg   <= id.dwreg;
         r_m2reg  <= id.dm2reg;
         r_wmem   <= id.dwmem;
         r_shift  <= id.dshift;
         r_aluimm <= id.daluimm;
         r_jal    <= id.djal;
      end
   end

   fwd_mux #(.XLEN(XLEN), .RNW(RNW)) u_fwd_rs (
      .rn     (r_rs),
      .val    (r_a),
      .mwreg  (mwreg),
      .mm2reg (mm2reg),
      .mrn    (mrn),
      .malu   (malu),
      .wwreg  (wwreg),
      .wrn    (wrn),
      .wdata  (wdata),
      .fwd    (w_fwd_rs)
   );

   fwd_mux #(.XLEN(XLEN), .RNW(RNW)) u_fwd_rt (
      .rn     (r_rt),
      .val    (r_b),
      .mwreg  (mwreg),
      .mm2reg (mm2reg),
      .mrn    (mrn),
      .malu   (malu),
      .wwreg  (wwreg),
      .wrn    (wrn),
      .wdata  (wdata),
      .fwd    (w_fwd_rt)
   );

   always_comb begin
      ea = w_fwd_rs;
      if (r_shift)
         ea = {{(XLEN-5){1'b0}}, r_sa};
      else if (r_jal)
         ea = r_pc4;
   end

   always_comb begin
      eb = w_fwd_rt;
      if (r_aluimm)
         eb = r_imm;
      else if (r_jal)
         eb = XLEN'(4);
   end

   assign estore = w_fwd_rt;
   assign ealuc  = r_aluc;
   assign ern    = r_rn;
   assign ewreg  = r_wreg;
   assign em2reg = r_m2reg;
   assign ewmem  = r_wmem;

   assign id.load_use = r_m2reg & (r_rn != RNW'(REG_ZERO)) &
                        ((id.dusers & (r_rn == id.drs)) | (id.duset & (r_rn == id.drt)));
endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  tb_id_ex_stage : directed checks of the ID/EX stage
//  Revision: 1.0
// ============================================================================
module tb_id_ex_stage;
   logic        clk = 1'b0;
   logic        clrn;
   logic        hold;
   logic        flush;
   logic        mwreg, mm2reg, wwreg;
   logic [4:0]  mrn, wrn;
   logic [31:0] malu, wdata;
   logic [31:0] ea, eb, estore;
   logic [3:0]  ealuc;
   logic [4:0]  ern;
   logic        ewreg, em2reg, ewmem;

   int checks = 0;
   int fails  = 0;

   id_ex_stage_if #(.XLEN(32), .RNW(5)) ifc ();

   id_ex_stage #(.XLEN(32), .RNW(5)) dut (
      .clk    (clk),
      .clrn   (clrn),
      .hold   (hold),
      .flush  (flush),
      .id     (ifc.slave),
      .mwreg  (mwreg),
      .mm2reg (mm2reg),
      .mrn    (mrn),
      .malu   (malu),
      .wwreg  (wwreg),
      .wrn    (wrn),
      .wdata  (wdata),
      .ea     (ea),
      .eb     (eb),
      .ealuc  (ealuc),
      .estore (estore),
      .ern    (ern),
      .ewreg  (ewreg),
      .em2reg (em2reg),
      .ewmem  (ewmem)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_d();
      ifc.da = '0; ifc.db = '0; ifc.dimm = '0; ifc.dsa = '0; ifc.dpc4 = '0;
      ifc.drs = '0; ifc.drt = '0; ifc.drn = '0; ifc.daluc = '0;
      ifc.dwreg = 0; ifc.dm2reg = 0; ifc.dwmem = 0; ifc.dshift = 0;
      ifc.daluimm = 0; ifc.djal = 0; ifc.dusers = 0; ifc.duset = 0;
   endtask

   task automatic clr_mw();
      mwreg = 0; mm2reg = 0; mrn = '0; malu = '0;
      wwreg = 0; wrn = '0; wdata = '0;
   endtask

   task automatic set_add_r3();
      clr_d();
      ifc.da = 32'd5; ifc.db = 32'd7; ifc.drs = 5'd1; ifc.drt = 5'd2; ifc.drn = 5'd3;
      ifc.daluc = 4'b0000; ifc.dwreg = 1; ifc.dusers = 1; ifc.duset = 1;
   endtask

   initial begin
      clrn = 0; hold = 0; flush = 0;
      clr_mw();
      set_add_r3();
      tick(); tick();
      // reset state with valid inputs presented
      chk("rst_ewreg", 32'(ewreg), 32'd0);
      chk("rst_ern", 32'(ern), 32'd0);
      chk("rst_ealuc", 32'(ealuc), 32'd0);
      chk("rst_ea", ea, 32'd0);
      chk("rst_eb", eb, 32'd0);
      chk("rst_estore", estore, 32'd0);
      chk("rst_load_use", 32'(ifc.load_use), 32'd0);

      clrn = 1;
      tick();
      chk("add_ea", ea, 32'd5);
      chk("add_eb", eb, 32'd7);
      chk("add_ealuc", 32'(ealuc), 32'd0);
      chk("add_ern", 32'(ern), 32'd3);
      chk("add_ewreg", 32'(ewreg), 32'd1);

      // asynchronous reset mid-stream
      ifc.daluc = 4'b0100; ifc.dwmem = 1;
      tick();
      chk("sub_ealuc", 32'(ealuc), 32'h4);
      clrn = 0;
      #1;
      chk("mid_rst_ern", 32'(ern), 32'd0);
      chk("mid_rst_ewreg", 32'(ewreg), 32'd0);
      chk("mid_rst_ewmem", 32'(ewmem), 32'd0);
      chk("mid_rst_ealuc", 32'(ealuc), 32'd0);
      chk("mid_rst_ea", ea, 32'd0);
      clrn = 1;

      // forwarding priority on rs=r4, rt=r5
      clr_d();
      ifc.drs = 5'd4; ifc.da = 32'd1; ifc.drt = 5'd5; ifc.db = 32'd2; ifc.drn = 5'd6; ifc.dwreg = 1;
      tick();
      mwreg = 1; mrn = 5'd4; malu = 32'hAAAA;
      wwreg = 1; wrn = 5'd4; wdata = 32'hBBBB;
      #1 chk("fwd_mem_wins", ea, 32'hAAAA);
      chk("fwd_rt_none", eb, 32'd2);
      mwreg = 0;
      #1 chk("fwd_wb", ea, 32'hBBBB);
      mwreg = 1; mrn = 5'd0; wrn = 5'd0;
      #1 chk("fwd_r0_none", ea, 32'd1);
      wrn = 5'd5;
      #1 chk("fwd_rt_wb_eb", eb, 32'hBBBB);
      chk("fwd_rt_wb_store", estore, 32'hBBBB);
      mrn = 5'd5;
      #1 chk("fwd_rt_mem_store", estore, 32'hAAAA);
      // load in MEM never forwards
      mm2reg = 1; mrn = 5'd4; wwreg = 0;
      #1 chk("fwd_load_mem_da", ea, 32'd1);
      wwreg = 1; wrn = 5'd4;
      #1 chk("fwd_load_mem_wb", ea, 32'hBBBB);
      clr_mw();

      // load-use detection
      clr_d();
      ifc.drs = 5'd1; ifc.da = 32'h40; ifc.dimm = 32'd4; ifc.daluimm = 1;
      ifc.drn = 5'd8; ifc.dwreg = 1; ifc.dm2reg = 1;
      tick();
      chk("lw_em2reg", 32'(em2reg), 32'd1);
      chk("lw_ern", 32'(ern), 32'd8);
      clr_d();
      ifc.drs = 5'd2; ifc.drt = 5'd8; ifc.duset = 1;
      #1 chk("lu_rt", 32'(ifc.load_use), 32'd1);
      ifc.duset = 0;
      #1 chk("lu_rt_unused", 32'(ifc.load_use), 32'd0);
      ifc.drs = 5'd8; ifc.dusers = 1;
      #1 chk("lu_rs", 32'(ifc.load_use), 32'd1);
      hold = 1;
      #1 chk("lu_hold", 32'(ifc.load_use), 32'd1);
      hold = 0;
      clr_d();
      ifc.drn = 5'd0; ifc.dm2reg = 1;
      tick();
      ifc.drs = 5'd0; ifc.drt = 5'd0; ifc.dusers = 1; ifc.duset = 1;
      #1 chk("lu_r0", 32'(ifc.load_use), 32'd0);

      // hold keeps contents while inputs change
      clr_d();
      ifc.da = 32'h10; ifc.db = 32'h20; ifc.drs = 5'd1; ifc.drt = 5'd2;
      ifc.drn = 5'd9; ifc.daluc = 4'b0100; ifc.dwreg = 1;
      tick();
      chk("sub_ea", ea, 32'h10);
      hold = 1;
      for (int i = 0; i < 3; i++) begin
         ifc.da = 32'h100 + i; ifc.drn = 5'(10 + i); ifc.daluc = 4'b0001; ifc.dwmem = 1;
         tick();
         chk("hold_ea", ea, 32'h10);
         chk("hold_ern", 32'(ern), 32'd9);
         chk("hold_ealuc", 32'(ealuc), 32'h4);
         chk("hold_ewmem", 32'(ewmem), 32'd0);
      end
      flush = 1;
      tick();
      chk("flush_ern", 32'(ern), 32'd0);
      chk("flush_ewreg", 32'(ewreg), 32'd0);
      chk("flush_ealuc", 32'(ealuc), 32'd0);
      chk("flush_ea", ea, 32'd0);
      hold = 0; flush = 0;

      // shift amount select
      clr_d();
      ifc.dshift = 1; ifc.dsa = 5'd9; ifc.db = 32'h1; ifc.da = 32'h77; ifc.drt = 5'd2;
      ifc.drn = 5'd5; ifc.daluc = 4'b0011; ifc.dwreg = 1;
      tick();
      chk("sll_ea", ea, 32'd9);
      chk("sll_eb", eb, 32'd1);
      chk("sll_ealuc", 32'(ealuc), 32'h3);

      // immediate select
      clr_d();
      ifc.daluimm = 1; ifc.dimm = 32'hFFFFFFFF; ifc.da = 32'd3; ifc.db = 32'h55;
      ifc.drs = 5'd1; ifc.drn = 5'd2; ifc.dwreg = 1;
      tick();
      chk("addi_ea", ea, 32'd3);
      chk("addi_eb", eb, 32'hFFFFFFFF);
      chk("addi_estore", estore, 32'h55);

      // jal forces ADD and r31
      clr_d();
      ifc.djal = 1; ifc.dpc4 = 32'h100; ifc.daluc = 4'b0101; ifc.drn = 5'd7;
      ifc.da = 32'h9; ifc.db = 32'h9; ifc.dwreg = 1;
      tick();
      chk("jal_ea", ea, 32'h100);
      chk("jal_eb", eb, 32'd4);
      chk("jal_ealuc", 32'(ealuc), 32'd0);
      chk("jal_ern", 32'(ern), 32'd31);
      chk("jal_ewreg", 32'(ewreg), 32'd1);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register and operand-select stage sitting directly upstream of the ALU in the five-stage MIPS datapath.
- Captures decoded ID-stage fields each cycle and applies EX-stage forwarding from the MEM and WB stages.
- Drives the ALU's a, b and aluc inputs.
- Also reports load-use hazards back to ID, and carries destination/control fields forward to the EX/MEM register.

Parameters:
- XLEN, 32, datapath width.
- RNW, 5, register-number width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- clrn  in  1  asynchronous active-low reset.
- hold  in  1  keep current register contents.
- flush  in  1  load a bubble.
- da, db  in  XLEN  ID register-file reads of rs and rt.
- dimm  in  XLEN  extended immediate.
- dsa  in  5  shift amount.
- dpc4  in  XLEN  PC+4.
- drs, drt, drn  in  RNW  source and destination register numbers.
- daluc  in  4  ALU op.
- dwreg, dm2reg, dwmem  in  1 each  register write, load, store.
- dshift, daluimm, djal  in  1 each  operand-select controls.
- dusers, duset  in  1 each  instruction reads rs / rt.
- mwreg, mm2reg  in  1 each  MEM-stage write and load flags.
- mrn  in  RNW  MEM-stage destination.
- malu  in  XLEN  MEM-stage ALU result.
- wwreg  in  1  WB-stage write enable.
- wrn  in  RNW  WB-stage destination.
- wdata  in  XLEN  WB-stage write data.
- ea, eb  out  XLEN  ALU operands a, b.
- ealuc  out  4  ALU op.
- estore  out  XLEN  forwarded rt value for stores.
- ern  out  RNW  destination register.
- ewreg, em2reg, ewmem  out  1 each  registered write, load, store flags.
- load_use  out  1  hazard request to ID.

Behaviour:
- Reset (clrn=0, async): all registered fields cleared to 0. This is the bubble state (ern=0, all control flags 0, ealuc=0000/ADD).
- Outputs during reset: ea=0, eb=0, estore=0, load_use=0.
- Edge priority: clrn > flush > hold > load.
  - flush=1: bubble captured, even when hold=1.
  - hold=1 and flush=0: no register changes.
  - Otherwise: all d* fields captured.
- Latency: one cycle from ID fields to the EX outputs. ea, eb and estore are combinational from the registered fields plus the current MEM/WB inputs.
- Forwarding, computed separately for the registered rs and rt values (fwd_rs, fwd_rt):
  - Register 0 is never forwarded.
  - MEM hit: mwreg=1 and mm2reg=0 and mrn equals the register → malu.
  - Else WB hit: wwreg=1 and wrn equals the register → wdata.
  - Else the registered da/db.
  - When MEM and WB both hit, MEM wins (it is younger).
- Operand select:
  - ea = {27'b0, esa} when eshift; epc4 when ejal; otherwise fwd_rs.
  - eb = eimm when ealuimm; 32'd4 when ejal; otherwise fwd_rt.
  - estore = fwd_rt always.
- jal capture: ealuc is captured as 0000 (ADD) and ern as 31, regardless of daluc/drn.
- load_use (combinational) = em2reg & (ern!=0) & ((dusers & ern==drs) | (duset & ern==drt)).
  - Upstream responds by holding PC/IF-ID and asserting flush here for exactly one cycle.
  - load_use is not gated by hold.
- Register-file write-before-read in the same cycle is the register file's responsibility; this block forwards only in EX.
- Mid-operation reset returns to the bubble state immediately. No X on any output after reset.

Decomposition:
- Shared package alu_pkg:
  - ALUC_ADD=4'b0000, ALUC_SUB=4'b0100, ALUC_AND=4'b0001, ALUC_OR=4'b0101, ALUC_XOR=4'b0010, ALUC_LUI=4'b0110, ALUC_SLL=4'b0011, ALUC_SRL=4'b0111, ALUC_SRA=4'b1111, ALUC_LE=4'b1011.
  - REG_RA=5'd31, REG_ZERO=5'd0.
- One sub-module, fwd_mux: inputs are register number, registered value, and the MEM/WB hit fields; output is the forwarded value. Instantiated twice (rs, rt).

Test Plan:
- Reset/bubble: clrn=0 mid-stream with valid d* inputs → ewreg=0, ern=0, ealuc=0000, ea=eb=0. Release, load add r3,r1,r2 (da=5, db=7) → next cycle ea=5, eb=7, ealuc=0000, ern=3, ewreg=1.
- Forward priority: registered rs=r4, da=1; mwreg=1, mrn=4, malu=32'hAAAA; wwreg=1, wrn=4, wdata=32'hBBBB → ea=32'hAAAA. Drop mwreg → ea=32'hBBBB. Set mrn=0 and wrn=0 → ea=1.
- No forwarding from a load in MEM: mm2reg=1, mwreg=1, mrn=4 → ea uses the WB value or da, never malu.
- Load-use: EX holds lw with ern=8; ID presents drt=8, duset=1 → load_use=1. With duset=0 → 0. With ern=0 → 0.
- hold/flush: hold=1 for 3 cycles while d* inputs change → outputs constant. hold=1 and flush=1 together → bubble captured next edge.
- Shift/imm/jal select:
  - sll with dsa=5'd9, db=32'h1 → ea=9, eb=1, ealuc=0011.
  - addi with dimm=32'hFFFFFFFF → eb=32'hFFFFFFFF.
  - jal with dpc4=32'h100 → ea=32'h100, eb=4, ealuc=0000, ern=31.
